// File: rtl/avalon_accum_slave_if.sv
// Avalon-MM slave bus bundle for the accumulator peripheral.
// The master drives the strobes, address and write data; the slave returns read data.
interface avalon_accum_slave_if;
   logic        avs_chipselect;
   logic [2:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_chipselect,
      output avs_address,
      output avs_read,
      output avs_write,
      output avs_byteenable,
      output avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_chipselect,
      input  avs_address,
      input  avs_read,
      input  avs_write,
      input  avs_byteenable,
      input  avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/avalon_accum_slave.sv
// Avalon-MM accumulator slave: debounced pushbuttons add the switch value into an
// 8-bit accumulator or clear it, with CTRL/ACC/SW/STATUS/COUNT registers and a level irq.
module avalon_accum_slave #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   avalon_accum_slave_if.slave        avs,
   input  logic [7:0]                 sw_in,
   input  logic                       key_acc_n,
   input  logic                       key_clr_n,
   output logic [7:0]                 led_out,
   output logic                       irq
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REL_WAIT
   } deb_state_e;

   logic [7:0]       sw_meta_q;
   logic [7:0]       sw_sync_q;
   logic [1:0]       key_meta_q;
   logic [1:0]       key_sync_q;
   deb_state_e       deb_state_q [2];
   logic [CNT_W-1:0] deb_cnt_q   [2];
   logic [1:0]       press_q;

   logic [1:0]       ctrl_q,     ctrl_d;
   logic [7:0]       acc_q,      acc_d;
   logic [2:0]       status_q,   status_d;
   logic [15:0]      count_q,    count_d;
   logic [31:0]      readdata_q, readdata_d;

   logic             bus_wr;
   logic             bus_rd;
   logic             acc_pulse;
   logic             clr_pulse;
   logic             acc_bus_wr;
   logic [8:0]       sum;

   wire unused_bus_bits = &{1'b0, avs.avs_writedata[31:16], avs.avs_byteenable[3:2]};

   // Index 0 is the accumulate key, index 1 the clear key; idle level is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         key_meta_q <= 2'b11;
         key_sync_q <= 2'b11;
      end else begin
         sw_meta_q  <= sw_in;
         sw_sync_q  <= sw_meta_q;
         key_meta_q <= {key_clr_n, key_acc_n};
         key_sync_q <= key_meta_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            deb_state_q[k] <= IDLE;
            deb_cnt_q[k]   <= '0;
            press_q[k]     <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            press_q[k] <= 1'b0;
            unique case (deb_state_q[k])
               IDLE: begin
                  if (!key_sync_q[k]) begin
                     deb_state_q[k] <= PRESS_WAIT;
                     deb_cnt_q[k]   <= CNT_ONE;
                  end
               end
               PRESS_WAIT: begin
                  if (key_sync_q[k]) begin
                     deb_state_q[k] <= IDLE;
                  end else if (deb_cnt_q[k] == CNT_LAST) begin
                     deb_state_q[k] <= HELD;
                     press_q[k]     <= 1'b1;
                  end else begin
                     deb_cnt_q[k] <= deb_cnt_q[k] + CNT_ONE;
                  end
               end
               HELD: begin
                  if (key_sync_q[k]) begin
                     deb_state_q[k] <= REL_WAIT;
                     deb_cnt_q[k]   <= CNT_ONE;
                  end
               end
               REL_WAIT: begin
                  if (!key_sync_q[k]) begin
                     deb_state_q[k] <= HELD;
                  end else if (deb_cnt_q[k] == CNT_LAST) begin
                     deb_state_q[k] <= IDLE;
                  end else begin
                     deb_cnt_q[k] <= deb_cnt_q[k] + CNT_ONE;
                  end
               end
               default: deb_state_q[k] <= IDLE;
            endcase
         end
      end
   end

   // Bus writes land first; hardware events then override them (clear beats write beats add).
   always_comb begin
      bus_wr     = avs.avs_chipselect & avs.avs_write;
      bus_rd     = avs.avs_chipselect & avs.avs_read;
      acc_pulse  = press_q[0] & ctrl_q[0];
      clr_pulse  = press_q[1] & ctrl_q[0];
      acc_bus_wr = bus_wr && (avs.avs_address == 3'd1) && avs.avs_byteenable[0];
      sum        = {1'b0, acc_q} + {1'b0, sw_sync_q};

      ctrl_d     = ctrl_q;
      acc_d      = acc_q;
      status_d   = status_q;
      count_d    = count_q;
      readdata_d = readdata_q;

      if (bus_wr) begin
         unique case (avs.avs_address)
            3'd0: if (avs.avs_byteenable[0]) ctrl_d = avs.avs_writedata[1:0];
            3'd1: if (avs.avs_byteenable[0]) acc_d = avs.avs_writedata[7:0];
            3'd3: if (avs.avs_byteenable[0]) status_d = status_q & ~avs.avs_writedata[2:0];
            3'd4: begin
               if (avs.avs_byteenable[0]) count_d[7:0]  = avs.avs_writedata[7:0];
               if (avs.avs_byteenable[1]) count_d[15:8] = avs.avs_writedata[15:8];
            end
            default: ;
         endcase
      end

      if (clr_pulse) begin
         acc_d       = '0;
         status_d[2] = 1'b1;
      end else if (acc_pulse && !acc_bus_wr) begin
         acc_d       = sum[7:0];
         status_d[0] = 1'b1;
         if (sum[8]) status_d[1] = 1'b1;
         if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end

      if (bus_rd) begin
         unique case (avs.avs_address)
            3'd0:    readdata_d = {30'd0, ctrl_q};
            3'd1:    readdata_d = {24'd0, acc_q};
            3'd2:    readdata_d = {24'd0, sw_sync_q};
            3'd3:    readdata_d = {29'd0, status_q};
            3'd4:    readdata_d = {16'd0, count_q};
            default: readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q     <= '0;
         acc_q      <= '0;
         status_q   <= '0;
         count_q    <= '0;
         readdata_q <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         acc_q      <= acc_d;
         status_q   <= status_d;
         count_q    <= count_d;
         readdata_q <= readdata_d;
      end
   end

   assign avs.avs_readdata = readdata_q;
   assign led_out          = acc_q;
   assign irq              = ctrl_q[1] & (status_q[0] | status_q[1]);
endmodule

// File: tb/tb_avalon_accum_slave.sv
// Self-checking bench for avalon_accum_slave: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_avalon_accum_slave;
   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] sw_in;
   logic       key_acc_n;
   logic       key_clr_n;
   logic [7:0] led_out;
   logic       irq;

   int checks   = 0;
   int failures = 0;

   avalon_accum_slave_if bus();

   avalon_accum_slave #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .avs       (bus),
      .sw_in     (sw_in),
      .key_acc_n (key_acc_n),
      .key_clr_n (key_clr_n),
      .led_out   (led_out),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Model state: architectural registers plus key/switch history and accepted key levels.
   logic [1:0]  m_ctrl;
   logic [7:0]  m_acc;
   logic [2:0]  m_status;
   logic [15:0] m_count;
   logic [31:0] m_rdata;
   logic [1:0]  key_h1, key_h2;
   logic [7:0]  sw_h1, sw_h2;
   bit          accepted [2];
   int          run [2];
   logic [1:0]  pend;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk) begin : model_and_compare
      logic        wr, rd, acc_written;
      logic [1:0]  seen, n_ctrl;
      logic [7:0]  n_acc;
      logic [2:0]  n_status;
      logic [15:0] n_count, mask;
      int          s;
      if (!reset_n) begin
         m_ctrl = '0; m_acc = '0; m_status = '0; m_count = '0; m_rdata = '0;
         key_h1 = 2'b11; key_h2 = 2'b11; sw_h1 = '0; sw_h2 = '0;
         accepted = '{0, 0}; run = '{0, 0}; pend = 2'b00;
      end else begin
         wr = bus.avs_chipselect & bus.avs_write;
         rd = bus.avs_chipselect & bus.avs_read;
         if (rd) begin
            case (bus.avs_address)
               3'd0:    m_rdata = {30'b0, m_ctrl};
               3'd1:    m_rdata = {24'b0, m_acc};
               3'd2:    m_rdata = {24'b0, sw_h2};
               3'd3:    m_rdata = {29'b0, m_status};
               3'd4:    m_rdata = {16'b0, m_count};
               default: m_rdata = '0;
            endcase
         end
         n_ctrl = m_ctrl; n_acc = m_acc; n_status = m_status; n_count = m_count;
         acc_written = 1'b0;
         if (wr && bus.avs_byteenable[0]) begin
            case (bus.avs_address)
               3'd0: n_ctrl = bus.avs_writedata[1:0];
               3'd1: begin n_acc = bus.avs_writedata[7:0]; acc_written = 1'b1; end
               3'd3: n_status = m_status & ~bus.avs_writedata[2:0];
               default: ;
            endcase
         end
         if (wr && bus.avs_address == 3'd4) begin
            mask    = {{8{bus.avs_byteenable[1]}}, {8{bus.avs_byteenable[0]}}};
            n_count = (m_count & ~mask) | (bus.avs_writedata[15:0] & mask);
         end
         if (m_ctrl[0] && pend[1]) begin
            n_acc = '0;
            n_status[2] = 1'b1;
         end else if (m_ctrl[0] && pend[0] && !acc_written) begin
            s = int'(m_acc) + int'(sw_h2);
            n_acc = 8'(s % 256);
            n_status[0] = 1'b1;
            if (s > 255) n_status[1] = 1'b1;
            n_count = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
         end
         m_ctrl = n_ctrl; m_acc = n_acc; m_status = n_status; m_count = n_count;
         // A key level is accepted once it differs from the accepted level DEB samples in a row.
         seen = key_h2;
         pend = 2'b00;
         for (int k = 0; k < 2; k++) begin
            if ((seen[k] == 1'b0) != accepted[k]) begin
               run[k]++;
               if (run[k] == DEB) begin
                  accepted[k] = !accepted[k];
                  run[k] = 0;
                  if (accepted[k]) pend[k] = 1'b1;
               end
            end else begin
               run[k] = 0;
            end
         end
         key_h2 = key_h1; key_h1 = {key_clr_n, key_acc_n};
         sw_h2  = sw_h1;  sw_h1  = sw_in;
      end
      #1;
      checkOutput("led_out", {24'b0, led_out}, {24'b0, m_acc});
      checkOutput("irq", {31'b0, irq}, {31'b0, m_ctrl[1] & (m_status[0] | m_status[1])});
      checkOutput("readdata", bus.avs_readdata, m_rdata);
   end

   task automatic busWrite(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus.avs_chipselect = 1'b1; bus.avs_write = 1'b1; bus.avs_read = 1'b0;
      bus.avs_address = addr; bus.avs_writedata = data; bus.avs_byteenable = be;
      @(negedge clk);
      bus.avs_chipselect = 1'b0; bus.avs_write = 1'b0;
   endtask

   task automatic busRead(input logic [2:0] addr, output logic [31:0] data);
      bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1; bus.avs_write = 1'b0;
      bus.avs_address = addr;
      @(negedge clk);
      data = bus.avs_readdata;
      bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0;
   endtask

   task automatic driveAcc(input logic lvl, input int n);
      key_acc_n = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic pressAcc(input int low_cycles);
      driveAcc(1'b0, low_cycles);
      driveAcc(1'b1, DEB + 4);
   endtask

   task automatic applyStimulus(input int cycles);
      int rem_acc = 1;
      int rem_clr = 1;
      int rst_left = 0;
      int op;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) reset_n = 1'b1;
         end else if ($urandom_range(0, 599) == 0) begin
            reset_n = 1'b0;
            rst_left = 2;
         end
         rem_acc--;
         if (rem_acc == 0) begin
            key_acc_n = ~key_acc_n;
            rem_acc = key_acc_n ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 8));
         end
         rem_clr--;
         if (rem_clr == 0) begin
            key_clr_n = ~key_clr_n;
            rem_clr = key_clr_n ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 8));
         end
         if ($urandom_range(0, 15) == 0) sw_in = 8'($urandom);
         op = int'($urandom_range(0, 3));
         bus.avs_chipselect = (op != 0);
         bus.avs_read       = (op == 1) || (op == 0 && $urandom_range(0, 1) == 1);
         bus.avs_write      = (op == 2);
         bus.avs_address    = 3'($urandom_range(0, 7));
         bus.avs_byteenable = 4'($urandom);
         bus.avs_writedata  = $urandom;
         if (op == 2 && bus.avs_address == 3'd0)
            bus.avs_writedata[0] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
      key_acc_n = 1'b1; key_clr_n = 1'b1;
      repeat (DEB + 6) @(negedge clk);
   endtask

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      reset_n = 1'b0; sw_in = '0; key_acc_n = 1'b1; key_clr_n = 1'b1;
      bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
      bus.avs_address = '0; bus.avs_byteenable = '0; bus.avs_writedata = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_led", {24'b0, led_out}, 32'h0);
      checkOutput("reset_irq", {31'b0, irq}, 32'h0);
      checkOutput("reset_readdata", bus.avs_readdata, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] accumulate 0x25 from reset");
      busWrite(3'd0, 32'h1, 4'hF);
      sw_in = 8'h25;
      pressAcc(10);
      busRead(3'd1, rd); checkOutput("acc_0x25", rd, 32'h25);
      checkOutput("led_0x25", {24'b0, led_out}, 32'h25);
      checkOutput("model_acc_0x25", {24'b0, m_acc}, 32'h25);
      busRead(3'd4, rd); checkOutput("count_1", rd, 32'h1);
      busRead(3'd3, rd); checkOutput("status_evt", rd, 32'h1);

      $display("[TB] overflow and interrupt");
      busWrite(3'd1, 32'hF0, 4'hF);
      sw_in = 8'h20;
      pressAcc(6);
      busRead(3'd1, rd); checkOutput("acc_wrap", rd, 32'h10);
      busRead(3'd3, rd); checkOutput("status_ovf", rd, 32'h3);
      checkOutput("model_status_ovf", {29'b0, m_status}, 32'h3);
      busWrite(3'd0, 32'h3, 4'hF);
      checkOutput("irq_on", {31'b0, irq}, 32'h1);
      busWrite(3'd3, 32'h3, 4'hF);
      checkOutput("irq_off", {31'b0, irq}, 32'h0);

      $display("[TB] bounce rejection");
      driveAcc(1'b0, 3); driveAcc(1'b1, 1); driveAcc(1'b0, 3); driveAcc(1'b1, DEB + 6);
      busRead(3'd4, rd); checkOutput("bounce_no_pulse", rd, 32'h2);
      pressAcc(DEB);
      busRead(3'd4, rd); checkOutput("stable_one_pulse", rd, 32'h3);
      busRead(3'd1, rd); checkOutput("acc_0x30", rd, 32'h30);

      $display("[TB] clear coincident with ACC write");
      key_clr_n = 1'b0;
      repeat (6) @(negedge clk);
      busWrite(3'd1, 32'h55, 4'hF);
      key_clr_n = 1'b1;
      repeat (DEB + 4) @(negedge clk);
      busRead(3'd1, rd); checkOutput("clr_beats_write", rd, 32'h0);
      busRead(3'd3, rd); checkOutput("clr_evt", rd & 32'h4, 32'h4);

      $display("[TB] COUNT saturation and byte lanes");
      busWrite(3'd4, 32'hFFFF, 4'hF);
      pressAcc(6);
      busRead(3'd4, rd); checkOutput("count_saturate", rd, 32'hFFFF);
      busWrite(3'd4, 32'h0000_0012, 4'h1);
      busRead(3'd4, rd); checkOutput("count_lane0", rd, 32'hFF12);

      $display("[TB] reset mid-press");
      busWrite(3'd0, 32'h1, 4'hF);
      key_acc_n = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      key_acc_n = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      busRead(3'd0, rd); checkOutput("ctrl_after_reset", rd, 32'h0);
      busWrite(3'd0, 32'h1, 4'hF);
      repeat (DEB + 8) @(negedge clk);
      busRead(3'd1, rd); checkOutput("acc_after_reset", rd, 32'h0);
      busRead(3'd3, rd); checkOutput("status_after_reset", rd, 32'h0);
      busRead(3'd4, rd); checkOutput("count_no_pulse", rd, 32'h0);
      sw_in = 8'hA5;
      repeat (3) @(negedge clk);
      busRead(3'd2, rd); checkOutput("sw_read", rd, 32'h0000_00A5);
      busRead(3'd6, rd); checkOutput("unmapped_read", rd, 32'h0);

      $display("[TB] randomized traffic");
      applyStimulus(4000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
